// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding,
// word geometry and the default target memory size.
package inst_mem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        WRITE     = 3'd2,
        DONE      = 3'd3,
        ERR       = 3'd4
    } state_e;

    localparam int BYTES_PER_WORD    = 4;
    localparam int DEFAULT_MEM_DEPTH = 256;

endpackage

// File: rtl/byte_serializer.sv
// Holds one 32-bit word and presents it as BYTES_PER_WORD ordered byte
// strobes, most significant byte first, one per cycle after a load.
module byte_serializer
    import inst_mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] word_i,
    output logic        byteValid_o,
    output logic [7:0]  byteData_o,
    output logic [1:0]  byteOffset_o,
    output logic        lastByte_o
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [31:0] word_q;
    logic [1:0]  count_q;
    logic        active_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q   <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
        end else if (load_i) begin
            word_q   <= word_i;
            count_q  <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            count_q <= count_q + 2'd1;
            if (count_q == LAST_LANE) begin
                active_q <= 1'b0;
            end
        end
    end

    // Lane 0 is the top byte so memory ends up holding the word big-endian.
    always_comb begin
        byteValid_o  = active_q;
        byteOffset_o = count_q;
        lastByte_o   = active_q && (count_q == LAST_LANE);
        case (count_q)
            2'd0:    byteData_o = word_q[31:24];
            2'd1:    byteData_o = word_q[23:16];
            2'd2:    byteData_o = word_q[15:8];
            default: byteData_o = word_q[7:0];
        endcase
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// four byte writes per word, with bounds checking against MEM_DEPTH.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int COUNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        baseAddress,
    input  logic               wordValid,
    input  logic [31:0]        wordData,
    input  logic               lastWord,
    output logic               wordReady,
    output logic               memWriteEnable,
    output logic [31:0]        memWriteAddress,
    output logic [7:0]         memWriteData,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [COUNT_W-1:0] wordCount
);

    state_e             state_q, state_d;
    logic [31:0]        ptr_q, ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               last_q, last_d;

    logic        transfer;
    logic        overflow;
    logic        serLoad;
    logic        byteValid;
    logic        lastByte;
    logic [7:0]  byteData;
    logic [1:0]  byteOffset;
    logic [32:0] lastByteAddr;

    // 33-bit sum so a pointer near 2^32 is flagged instead of wrapping.
    assign lastByteAddr = {1'b0, ptr_q} + 33'(BYTES_PER_WORD - 1);
    assign overflow     = lastByteAddr > 33'(MEM_DEPTH - 1);
    assign transfer     = (state_q == WAIT_WORD) && wordValid;
    assign serLoad      = transfer && !overflow;

    byte_serializer u_serializer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (serLoad),
        .word_i      (wordData),
        .byteValid_o (byteValid),
        .byteData_o  (byteData),
        .byteOffset_o(byteOffset),
        .lastByte_o  (lastByte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        last_d  = last_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = WAIT_WORD;
                    ptr_d   = baseAddress;
                    count_d = '0;
                end
            end
            WAIT_WORD: begin
                if (transfer) begin
                    last_d  = lastWord;
                    state_d = overflow ? ERR : WRITE;
                end
            end
            WRITE: begin
                if (lastByte) begin
                    ptr_d   = ptr_q + 32'(BYTES_PER_WORD);
                    if (count_q != '1) begin
                        count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                    end
                    state_d = last_q ? DONE : WAIT_WORD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wordReady       = (state_q == WAIT_WORD);
        busy            = (state_q == WAIT_WORD) || (state_q == WRITE);
        done            = (state_q == DONE);
        error           = (state_q == ERR);
        wordCount       = count_q;
        memWriteEnable  = (state_q == WRITE) && byteValid;
        memWriteAddress = '0;
        memWriteData    = '0;
        if (memWriteEnable) begin
            memWriteAddress = ptr_q + {30'd0, byteOffset};
            memWriteData    = byteData;
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader: one task per scenario,
// each comparing DUT outputs against hand-derived expectations.
module tb_inst_mem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] baseAddress;
    logic        wordValid;
    logic [31:0] wordData;
    logic        lastWord;
    logic        wordReady;
    logic        memWriteEnable;
    logic [31:0] memWriteAddress;
    logic [7:0]  memWriteData;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] wordCount;

    int total;
    int bad;
    int writeCount;
    logic [7:0] memImg [256];

    inst_mem_loader #(.MEM_DEPTH(256), .COUNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .baseAddress    (baseAddress),
        .wordValid      (wordValid),
        .wordData       (wordData),
        .lastWord       (lastWord),
        .wordReady      (wordReady),
        .memWriteEnable (memWriteEnable),
        .memWriteAddress(memWriteAddress),
        .memWriteData   (memWriteData),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .wordCount      (wordCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image built from observed byte writes, sampled mid-cycle.
    always @(negedge clk) begin
        if (memWriteEnable === 1'b1) begin
            memImg[memWriteAddress[7:0]] = memWriteData;
            writeCount = writeCount + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [31:0] d, input logic l);
        int waitCycles;
        waitCycles = 0;
        while (wordReady !== 1'b1 && waitCycles < 20) begin
            tick();
            waitCycles++;
        end
        total++;
        if (wordReady !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sendWord_timeout wordReady=%0b required=1", wordReady);
        end
        wordValid = 1'b1;
        wordData  = d;
        lastWord  = l;
        tick();
        wordValid = 1'b0;
        lastWord  = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; baseAddress = '0;
        wordValid = 1'b0; wordData = '0; lastWord = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++; if (wordReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_wordReady got=%0b exp=0", wordReady); end
        total++; if (memWriteEnable !== 1'b0) begin bad++; $display("[TB] FAIL reset_we got=%0b exp=0", memWriteEnable); end
        total++; if (memWriteAddress !== 32'd0) begin bad++; $display("[TB] FAIL reset_addr got=%0h exp=0", memWriteAddress); end
        total++; if (memWriteData !== 8'd0) begin bad++; $display("[TB] FAIL reset_data got=%0h exp=0", memWriteData); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
        total++; if (error !== 1'b0) begin bad++; $display("[TB] FAIL reset_error got=%0b exp=0", error); end
        total++; if (wordCount !== 16'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", wordCount); end
    endtask

    task automatic test_single_word();
        logic [7:0] expBytes [4];
        expBytes[0] = 8'h8C; expBytes[1] = 8'h22; expBytes[2] = 8'h00; expBytes[3] = 8'h04;
        start = 1'b1; baseAddress = 32'd0;
        tick();
        start = 1'b0;
        total++; if (wordReady !== 1'b1 || busy !== 1'b1) begin bad++; $display("[TB] FAIL single_ready got=%0b/%0b exp=1/1", wordReady, busy); end
        wordValid = 1'b1; wordData = 32'h8C220004; lastWord = 1'b1;
        tick();
        wordValid = 1'b0; lastWord = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (memWriteEnable !== 1'b1 || memWriteAddress !== 32'(k) || memWriteData !== expBytes[k]) begin
                bad++;
                $display("[TB] FAIL single_byte%0d got we=%0b a=%0d d=%0h exp we=1 a=%0d d=%0h",
                         k, memWriteEnable, memWriteAddress, memWriteData, k, expBytes[k]);
            end
            tick();
        end
        total++; if (memWriteEnable !== 1'b0 || memWriteAddress !== 32'd0 || memWriteData !== 8'd0) begin bad++; $display("[TB] FAIL single_idle_bus got we=%0b a=%0h d=%0h exp 0/0/0", memWriteEnable, memWriteAddress, memWriteData); end
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL single_done got done=%0b busy=%0b exp 1/0", done, busy); end
        total++; if (wordCount !== 16'd1) begin bad++; $display("[TB] FAIL single_count got=%0d exp=1", wordCount); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        int wIdx;
        logic xfer, expReady, expWe;
        logic [31:0] expAddr;
        logic [7:0] expData;
        words[0] = 32'h00112233; words[1] = 32'h44556677; words[2] = 32'h8899AABB;
        start = 1'b1; baseAddress = 32'd16;
        tick();
        start = 1'b0;
        wIdx = 0;
        wordValid = 1'b1; wordData = words[0]; lastWord = 1'b0;
        for (int c = 0; c < 16; c++) begin
            expReady = (c == 0) || (c == 5) || (c == 10);
            expWe    = (c % 5 != 0) && (c <= 14);
            expAddr  = expWe ? 32'(16 + 4 * (c / 5) + (c % 5) - 1) : 32'd0;
            expData  = expWe ? 8'(words[c / 5] >> (8 * (3 - ((c % 5) - 1)))) : 8'd0;
            total++;
            if (wordReady !== expReady || memWriteEnable !== expWe ||
                memWriteAddress !== expAddr || memWriteData !== expData) begin
                bad++;
                $display("[TB] FAIL b2b_cycle%0d got rdy=%0b we=%0b a=%0d d=%0h exp rdy=%0b we=%0b a=%0d d=%0h",
                         c, wordReady, memWriteEnable, memWriteAddress, memWriteData,
                         expReady, expWe, expAddr, expData);
            end
            xfer = wordReady && wordValid;
            tick();
            if (xfer) begin
                wIdx++;
                if (wIdx < 3) begin
                    wordData = words[wIdx];
                    lastWord = (wIdx == 2);
                end else begin
                    wordValid = 1'b0;
                    lastWord  = 1'b0;
                end
            end
        end
        total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done got done=%0b err=%0b exp 1/0", done, error); end
        total++; if (wordCount !== 16'd3) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=3", wordCount); end
    endtask

    task automatic test_overflow();
        logic [31:0] words [2];
        int wIdx;
        logic xfer, expReady, expWe;
        logic [31:0] expAddr;
        logic [7:0] expData;
        words[0] = 32'hA1B2C3D4; words[1] = 32'h55667788;
        start = 1'b1; baseAddress = 32'd252;
        tick();
        start = 1'b0;
        wIdx = 0;
        wordValid = 1'b1; wordData = words[0]; lastWord = 1'b0;
        for (int c = 0; c < 10; c++) begin
            expReady = (c == 0) || (c == 5);
            expWe    = (c >= 1) && (c <= 4);
            expAddr  = expWe ? 32'(252 + c - 1) : 32'd0;
            expData  = expWe ? 8'(words[0] >> (8 * (4 - c))) : 8'd0;
            total++;
            if (wordReady !== expReady || memWriteEnable !== expWe ||
                memWriteAddress !== expAddr || memWriteData !== expData) begin
                bad++;
                $display("[TB] FAIL ovf_cycle%0d got rdy=%0b we=%0b a=%0d d=%0h exp rdy=%0b we=%0b a=%0d d=%0h",
                         c, wordReady, memWriteEnable, memWriteAddress, memWriteData,
                         expReady, expWe, expAddr, expData);
            end
            xfer = wordReady && wordValid;
            tick();
            if (xfer) begin
                wIdx++;
                if (wIdx < 2) wordData = words[wIdx];
                else wordValid = 1'b0;
            end
        end
        total++; if (error !== 1'b1 || done !== 1'b0) begin bad++; $display("[TB] FAIL ovf_flags got err=%0b done=%0b exp 1/0", error, done); end
        total++; if (wordCount !== 16'd1) begin bad++; $display("[TB] FAIL ovf_count got=%0d exp=1", wordCount); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL ovf_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_start_ignored();
        start = 1'b1; baseAddress = 32'd100;
        tick();
        start = 1'b0;
        wordValid = 1'b1; wordData = 32'h01020304; lastWord = 1'b0;
        tick();
        wordValid = 1'b0;
        start = 1'b1; baseAddress = 32'd200;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (memWriteEnable !== 1'b1 || memWriteAddress !== 32'(100 + k) || memWriteData !== 8'(k + 1)) begin
                bad++;
                $display("[TB] FAIL ign_w1_byte%0d got we=%0b a=%0d d=%0h exp we=1 a=%0d d=%0h",
                         k, memWriteEnable, memWriteAddress, memWriteData, 100 + k, k + 1);
            end
            tick();
            start = 1'b0;
        end
        total++; if (wordReady !== 1'b1) begin bad++; $display("[TB] FAIL ign_ready got=%0b exp=1", wordReady); end
        start = 1'b1; baseAddress = 32'd200;
        wordValid = 1'b1; wordData = 32'h05060708; lastWord = 1'b1;
        tick();
        start = 1'b0; wordValid = 1'b0; lastWord = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (memWriteEnable !== 1'b1 || memWriteAddress !== 32'(104 + k) || memWriteData !== 8'(k + 5)) begin
                bad++;
                $display("[TB] FAIL ign_w2_byte%0d got we=%0b a=%0d d=%0h exp we=1 a=%0d d=%0h",
                         k, memWriteEnable, memWriteAddress, memWriteData, 104 + k, k + 5);
            end
            tick();
        end
        total++; if (done !== 1'b1 || wordCount !== 16'd2) begin bad++; $display("[TB] FAIL ign_end got done=%0b cnt=%0d exp 1/2", done, wordCount); end
    endtask

    task automatic test_reset_mid_write();
        int snap;
        start = 1'b1; baseAddress = 32'd40;
        tick();
        start = 1'b0;
        wordValid = 1'b1; wordData = 32'h11223344; lastWord = 1'b1;
        tick();
        wordValid = 1'b0; lastWord = 1'b0;
        tick();
        total++; if (memWriteEnable !== 1'b1 || memWriteAddress !== 32'd41 || memWriteData !== 8'h22) begin bad++; $display("[TB] FAIL rmw_byte1 got we=%0b a=%0d d=%0h exp 1/41/22", memWriteEnable, memWriteAddress, memWriteData); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        snap = writeCount;
        total++; if ({wordReady, memWriteEnable, busy, done, error} !== 5'b0 || memWriteAddress !== 32'd0 || memWriteData !== 8'd0 || wordCount !== 16'd0) begin
            bad++;
            $display("[TB] FAIL rmw_outputs got rdy=%0b we=%0b busy=%0b done=%0b err=%0b a=%0h d=%0h cnt=%0d exp all 0",
                     wordReady, memWriteEnable, busy, done, error, memWriteAddress, memWriteData, wordCount);
        end
        repeat (4) tick();
        total++; if (writeCount !== snap) begin bad++; $display("[TB] FAIL rmw_no_writes got=%0d exp=%0d", writeCount, snap); end
        start = 1'b1; baseAddress = 32'd8;
        tick();
        start = 1'b0;
        sendWord(32'hCAFEBABE, 1'b1);
        total++; if (done !== 1'b1 || wordCount !== 16'd1) begin bad++; $display("[TB] FAIL rmw_restart got done=%0b cnt=%0d exp 1/1", done, wordCount); end
        total++; if ({memImg[8], memImg[9], memImg[10], memImg[11]} !== 32'hCAFEBABE) begin bad++; $display("[TB] FAIL rmw_restart_mem got=%0h exp=cafebabe", {memImg[8], memImg[9], memImg[10], memImg[11]}); end
    endtask

    task automatic test_zero_ones();
        for (int i = 0; i < 8; i++) memImg[i] = 8'hAA;
        start = 1'b1; baseAddress = 32'd0;
        tick();
        start = 1'b0;
        sendWord(32'h00000000, 1'b0);
        sendWord(32'hFFFFFFFF, 1'b1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (memImg[i] !== ((i < 4) ? 8'h00 : 8'hFF)) begin
                bad++;
                $display("[TB] FAIL zo_byte%0d got=%0h exp=%0h", i, memImg[i], (i < 4) ? 8'h00 : 8'hFF);
            end
        end
        total++; if ({memImg[0], memImg[1], memImg[2], memImg[3]} !== 32'h00000000) begin bad++; $display("[TB] FAIL zo_word0 got=%0h exp=0", {memImg[0], memImg[1], memImg[2], memImg[3]}); end
        total++; if ({memImg[4], memImg[5], memImg[6], memImg[7]} !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL zo_word1 got=%0h exp=ffffffff", {memImg[4], memImg[5], memImg[6], memImg[7]}); end
        total++; if (done !== 1'b1 || wordCount !== 16'd2) begin bad++; $display("[TB] FAIL zo_end got done=%0b cnt=%0d exp 1/2", done, wordCount); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        writeCount = 0;
        for (int i = 0; i < 256; i++) memImg[i] = 8'h00;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_start_ignored();
        test_reset_mid_write();
        test_zero_ones();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
